ram_wb_ctrl: RTL and testbench

- Wishbone slave on the arbiter's x bus (downstream of ram_arb).
- Drives a synchronous single-port word RAM with byte-lane write enables.
- Has a one-entry posted-write buffer: writes ack early and drain in the background; reads stall behind a pending drain so they always return coherent data.
- Generates the pulsed x_ack the arbiter expects and forces x_rdt to zero whenever no read is being acked.

---
 rtl/ram_wb_ctrl_pkg.sv | 24 ++
 rtl/ram_wb_wbuf.sv | 51 +++++
 rtl/ram_wb_ctrl.sv | 159 +++++++++++++++
 tb/tb_ram_wb_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/ram_wb_ctrl_pkg.sv
// rtl/ram_wb_ctrl_pkg.sv - shared types and helpers for ram_wb_ctrl
package ram_wb_ctrl_pkg;

    localparam int WB_ADDR_W = 30;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_ACK   = 2'd1,
        RD_ISSUE = 2'd2,
        RD_ACK   = 2'd3
    } state_t;

    typedef struct packed {
        logic                 valid;
        logic [WB_ADDR_W-1:0] addr;
        logic [3:0]           sel;
        logic [31:0]          data;
    } wbuf_t;

    function automatic logic [WB_ADDR_W-1:0] word_addr(input logic [31:0] adr);
        return adr[31:2];
    endfunction

endpackage

// File: rtl/ram_wb_wbuf.sv
// rtl/ram_wb_wbuf.sv - one-entry posted-write buffer with load, drain and hit tracking
module ram_wb_wbuf
    import ram_wb_ctrl_pkg::*;
#(
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  wbuf_t             load_entry,
    input  logic              drain_en,
    input  logic [ADDR_W-1:0] rd_word,
    output wbuf_t             entry,
    output logic              draining,
    output logic              drain_next,
    output logic              hit
);

    wbuf_t entry_q, entry_d;
    logic  drain_q, drain_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            entry_q <= '0;
            drain_q <= 1'b0;
        end else begin
            entry_q <= entry_d;
            drain_q <= drain_d;
        end
    end

    // A freshly loaded entry waits one cycle before draining, so the RAM
    // write never lands in the cycle the write is acked.
    always_comb begin
        entry_d = entry_q;
        if (load) begin
            entry_d = load_entry;
        end else if (drain_q) begin
            entry_d.valid = 1'b0;
        end
        drain_d = entry_d.valid && !load && drain_en;
    end

    assign entry      = entry_q;
    assign draining   = drain_q;
    assign drain_next = drain_d;
    assign hit        = entry_q.valid
                        && (entry_q.addr == WB_ADDR_W'(rd_word))
                        && (entry_q.sel == 4'b1111);

endmodule

// File: rtl/ram_wb_ctrl.sv
// rtl/ram_wb_ctrl.sv - Wishbone slave for a single-port word RAM with posted writes
// Optional read forwarding from the write buffer: RAM_WB_CTRL_FWD_EN
module ram_wb_ctrl
    import ram_wb_ctrl_pkg::*;
#(
    parameter int WORDS  = 512,
    parameter int ADDR_W = $clog2(WORDS)
) (
    input  logic              wb_clk,
    input  logic              wb_rst_n,
    input  logic              x_cyc,
    input  logic              x_we,
    input  logic [3:0]        x_sel,
    input  logic [31:0]       x_adr,
    input  logic [31:0]       x_dat,
    output logic              x_ack,
    output logic [31:0]       x_rdt,
    output logic              m_en,
    output logic [3:0]        m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [31:0]       m_wdata,
    input  logic [31:0]       m_rdata
);

    state_t              state_q, state_d;
    logic                x_ack_q, x_ack_d;
    logic                m_en_q, m_en_d;
    logic [3:0]          m_we_q, m_we_d;
    logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
    logic [31:0]         m_wdata_q, m_wdata_d;
    logic                fwd_q, fwd_d;
    logic [31:0]         fwd_data_q, fwd_data_d;

    logic [WB_ADDR_W-1:0] word_full;
    logic [ADDR_W-1:0]    word;
    logic                 req;
    logic                 wb_load, wb_draining, wb_drain_next, wb_hit, drain_en;
    wbuf_t                wb_entry, wb_load_entry;
    logic                 unused_ok;

    assign word_full = word_addr(x_adr);
    assign word      = word_full[ADDR_W-1:0];
    assign req       = x_cyc && !x_ack_q;
    assign drain_en  = (state_d != RD_ISSUE);

    always_comb begin
        wb_load_entry       = '0;
        wb_load_entry.valid = 1'b1;
        wb_load_entry.addr  = WB_ADDR_W'(word);
        wb_load_entry.sel   = x_sel;
        wb_load_entry.data  = x_dat;
    end

    ram_wb_wbuf #(
        .ADDR_W(ADDR_W)
    ) u_wbuf (
        .clk        (wb_clk),
        .rst_n      (wb_rst_n),
        .load       (wb_load),
        .load_entry (wb_load_entry),
        .drain_en   (drain_en),
        .rd_word    (word),
        .entry      (wb_entry),
        .draining   (wb_draining),
        .drain_next (wb_drain_next),
        .hit        (wb_hit)
    );

    always_ff @(posedge wb_clk) begin
        if (!wb_rst_n) begin
            state_q    <= IDLE;
            x_ack_q    <= 1'b0;
            m_en_q     <= 1'b0;
            m_we_q     <= 4'b0;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
            fwd_q      <= 1'b0;
            fwd_data_q <= '0;
        end else begin
            state_q    <= state_d;
            x_ack_q    <= x_ack_d;
            m_en_q     <= m_en_d;
            m_we_q     <= m_we_d;
            m_addr_q   <= m_addr_d;
            m_wdata_q  <= m_wdata_d;
            fwd_q      <= fwd_d;
            fwd_data_q <= fwd_data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wb_load    = 1'b0;
        fwd_d      = 1'b0;
        fwd_data_d = '0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (x_we) begin
                        if (!wb_entry.valid || wb_draining) begin
                            wb_load = 1'b1;
                            state_d = WR_ACK;
                        end
                    end
`ifdef RAM_WB_CTRL_FWD_EN
                    else if (wb_hit) begin
                        state_d    = RD_ACK;
                        fwd_d      = 1'b1;
                        fwd_data_d = wb_entry.data;
                    end
`endif
                    else if (!wb_entry.valid) begin
                        state_d = RD_ISSUE;
                    end
                end
            end
            WR_ACK:   state_d = IDLE;
            RD_ISSUE: state_d = x_cyc ? RD_ACK : IDLE;
            RD_ACK:   state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // RAM strobes are registered from the next state, so a read issue and a
    // drain can never share a cycle: reads only issue with the buffer empty.
    always_comb begin
        x_ack_d   = (state_d == WR_ACK) || (state_d == RD_ACK);
        m_en_d    = 1'b0;
        m_we_d    = 4'b0;
        m_addr_d  = '0;
        m_wdata_d = '0;
        if (state_d == RD_ISSUE) begin
            m_en_d   = 1'b1;
            m_addr_d = word;
        end else if (wb_drain_next) begin
            m_en_d    = 1'b1;
            m_we_d    = wb_entry.sel;
            m_addr_d  = wb_entry.addr[ADDR_W-1:0];
            m_wdata_d = wb_entry.data;
        end
        x_rdt = '0;
        if (state_q == RD_ACK) begin
            x_rdt = fwd_q ? fwd_data_q : m_rdata;
        end
    end

    assign x_ack   = x_ack_q;
    assign m_en    = m_en_q;
    assign m_we    = m_we_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;

`ifdef RAM_WB_CTRL_FWD_EN
    assign unused_ok = ^{word_full[WB_ADDR_W-1:ADDR_W], wb_entry.addr[WB_ADDR_W-1:ADDR_W]};
`else
    assign unused_ok = ^{word_full[WB_ADDR_W-1:ADDR_W], wb_entry.addr[WB_ADDR_W-1:ADDR_W], wb_hit};
`endif

endmodule

// File: tb/tb_ram_wb_ctrl.sv
// tb/tb_ram_wb_ctrl.sv - self-checking bench for ram_wb_ctrl
module tb_ram_wb_ctrl;
    import ram_wb_ctrl_pkg::*;

    localparam int WORDS  = 512;
    localparam int ADDR_W = 9;
`ifdef RAM_WB_CTRL_FWD_EN
    localparam int LAT_FWD = 1;
`else
    localparam int LAT_FWD = 3;
`endif

    logic              wb_clk = 1'b0;
    logic              wb_rst_n;
    logic              x_cyc;
    logic              x_we;
    logic [3:0]        x_sel;
    logic [31:0]       x_adr;
    logic [31:0]       x_dat;
    logic              x_ack;
    logic [31:0]       x_rdt;
    logic              m_en;
    logic [3:0]        m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [31:0]       m_wdata;
    logic [31:0]       m_rdata;

    ram_wb_ctrl #(
        .WORDS  (WORDS),
        .ADDR_W (ADDR_W)
    ) u_dut (
        .wb_clk   (wb_clk),
        .wb_rst_n (wb_rst_n),
        .x_cyc    (x_cyc),
        .x_we     (x_we),
        .x_sel    (x_sel),
        .x_adr    (x_adr),
        .x_dat    (x_dat),
        .x_ack    (x_ack),
        .x_rdt    (x_rdt),
        .m_en     (m_en),
        .m_we     (m_we),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_rdata  (m_rdata)
    );

    always #5 wb_clk = ~wb_clk;

    // RAM model: word i starts as 0x5a000000 | i
    logic [31:0] mem [WORDS];
    logic        ram_init = 1'b0;

    always @(posedge wb_clk) begin
        if (!ram_init) begin
            for (int i = 0; i < WORDS; i++) mem[i] <= 32'h5a000000 | i;
            ram_init <= 1'b1;
        end else if (m_en) begin
            for (int b = 0; b < 4; b++)
                if (m_we[b]) mem[m_addr][8*b +: 8] <= m_wdata[8*b +: 8];
            m_rdata <= mem[m_addr];
        end
    end

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [31:0] exp_rdt;
        int          exp_lat;
    } vec_t;

    vec_t        vecs [14];
    logic [31:0] exp_q [$];
    int          checks   = 0;
    int          failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_zero_outputs(input string pfx);
        chk({pfx, "_x_ack"},   {31'b0, x_ack}, 32'h0);
        chk({pfx, "_x_rdt"},   x_rdt, 32'h0);
        chk({pfx, "_m_en"},    {31'b0, m_en}, 32'h0);
        chk({pfx, "_m_we"},    {28'b0, m_we}, 32'h0);
        chk({pfx, "_m_addr"},  32'(m_addr), 32'h0);
        chk({pfx, "_m_wdata"}, m_wdata, 32'h0);
        chk({pfx, "_state"},   32'(u_dut.state_q), 32'(IDLE));
        chk({pfx, "_wbuf_valid"}, {31'b0, u_dut.u_wbuf.entry_q.valid}, 32'h0);
    endtask

    // Raise a request one negedge from now, wait for ack, drop x_cyc at the ack negedge.
    task automatic do_access(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                             input logic [3:0] sel, input logic [31:0] exp_rdt,
                             input int exp_lat, input string name);
        int   lat;
        logic got;
        @(negedge wb_clk);
        chk({name, "_ack_gap"}, {31'b0, x_ack}, 32'h0);
        x_cyc = 1'b1; x_we = we; x_adr = adr; x_dat = dat; x_sel = sel;
        if (!we) exp_q.push_back(exp_rdt);
        lat = 0;
        got = 1'b0;
        while (!got && lat < 20) begin
            @(negedge wb_clk);
            lat++;
            if (x_ack) got = 1'b1;
            else chk({name, "_rdt_idle"}, x_rdt, 32'h0);
        end
        if (!got) begin
            chk({name, "_timeout"}, 32'h0, 32'h1);
            if (!we) void'(exp_q.pop_front());
        end else begin
            chk({name, "_latency"}, lat, exp_lat);
            if (we) chk({name, "_wr_rdt"}, x_rdt, 32'h0);
            else    chk({name, "_rdata"}, x_rdt, exp_q.pop_front());
        end
        x_cyc = 1'b0;
    endtask

    initial begin
        logic found;
        int   n;

        vecs[0]  = '{1'b1, 32'h10,   32'hcafecafe, 4'hf, 32'h0,        1};
        vecs[1]  = '{1'b0, 32'h10,   32'h0,        4'hf, 32'hcafecafe, LAT_FWD};
        vecs[2]  = '{1'b1, 32'h14,   32'hffffffff, 4'hf, 32'h0,        1};
        vecs[3]  = '{1'b1, 32'h14,   32'h000000aa, 4'h1, 32'h0,        1};
        vecs[4]  = '{1'b0, 32'h14,   32'h0,        4'hf, 32'hffffffaa, 3};
        vecs[5]  = '{1'b1, 32'h00,   32'h11111111, 4'hf, 32'h0,        1};
        vecs[6]  = '{1'b1, 32'h04,   32'h22222222, 4'hf, 32'h0,        1};
        vecs[7]  = '{1'b0, 32'h00,   32'h0,        4'hf, 32'h11111111, 3};
        vecs[8]  = '{1'b0, 32'h04,   32'h0,        4'hf, 32'h22222222, 2};
        vecs[9]  = '{1'b0, 32'h20,   32'h0,        4'hf, 32'h12343456, 2};
        vecs[10] = '{1'b0, 32'h24,   32'h0,        4'hf, 32'h5a000009, 2};
        vecs[11] = '{1'b0, 32'h1020, 32'h0,        4'hf, 32'h12343456, 2};
        vecs[12] = '{1'b1, 32'h28,   32'ha5a5a5a5, 4'h6, 32'h0,        1};
        vecs[13] = '{1'b0, 32'h28,   32'h0,        4'hf, 32'h5aa5a50a, 3};

        wb_rst_n = 1'b0;
        x_cyc = 1'b0; x_we = 1'b0; x_sel = 4'h0; x_adr = 32'h0; x_dat = 32'h0;
        repeat (3) @(negedge wb_clk);
        chk_zero_outputs("reset");
        wb_rst_n = 1'b1;

        do_access(1'b1, 32'h20, 32'h12343456, 4'hf, 32'h0, 1, "wr20");
        found = 1'b0;
        for (int i = 0; i < 2 && !found; i++) begin
            if (i > 0) @(negedge wb_clk);
            if (m_en && m_we == 4'hf && m_addr == 9'd8 && m_wdata == 32'h12343456) found = 1'b1;
        end
        chk("wr20_drain", {31'b0, found}, 32'h1);

        for (int v = 0; v < 14; v++)
            do_access(vecs[v].we, vecs[v].adr, vecs[v].dat, vecs[v].sel,
                      vecs[v].exp_rdt, vecs[v].exp_lat, $sformatf("vec%0d", v));

        // Read abandoned in the RD_ISSUE cycle
        @(negedge wb_clk);
        x_cyc = 1'b1; x_we = 1'b0; x_adr = 32'h8; x_sel = 4'hf;
        @(negedge wb_clk);
        chk("abort_issue_en",   {31'b0, m_en}, 32'h1);
        chk("abort_issue_addr", 32'(m_addr), 32'h2);
        x_cyc = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge wb_clk);
            chk("abort_no_ack", {31'b0, x_ack}, 32'h0);
            chk("abort_rdt",    x_rdt, 32'h0);
        end
        chk("abort_state", 32'(u_dut.state_q), 32'(IDLE));
        do_access(1'b0, 32'h8, 32'h0, 4'hf, 32'h5a000002, 2, "rd8_after_abort");

        // Reset during WR_ACK discards the buffered write
        @(negedge wb_clk);
        x_cyc = 1'b1; x_we = 1'b1; x_adr = 32'hc; x_dat = 32'h44444444; x_sel = 4'hf;
        n = 0;
        while (!x_ack && n < 20) begin
            @(negedge wb_clk);
            n++;
        end
        chk("rst_wr_latency", n, 1);
        chk("rst_no_drain", {31'b0, m_en && (m_we != 4'h0)}, 32'h0);
        wb_rst_n = 1'b0;
        x_cyc = 1'b0;
        @(negedge wb_clk);
        chk_zero_outputs("midreset");
        wb_rst_n = 1'b1;
        do_access(1'b0, 32'hc, 32'h0, 4'hf, 32'h5a000003, 2, "rdc_after_reset");

        chk("sb_empty", exp_q.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
